// File: rtl/jtcop_objdma_pkg.sv
// Shared constants and state encoding for the object-table DMA.
package jtcop_objdma_pkg;

  localparam int unsigned OBJ_AW = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StCopy  = 2'd2,
    StFlush = 2'd3
  } dma_st_e;

endpackage

// File: rtl/jtcop_objdma.sv
// Object-RAM to object-buffer DMA with CPU port sharing and ping-pong buffer banks.
module jtcop_objdma
  import jtcop_objdma_pkg::*;
#(
  parameter int unsigned AW         = OBJ_AW,
  parameter bit          WAIT_BLANK = 1'b1
) (
  input  logic          rst_i,
  input  logic          clk_i,
  input  logic          cen_i,
  input  logic          lvbl_i,
  input  logic          obj_copy_i,
  input  logic          mixpsel_i,
  input  logic          cpu_cs_i,
  input  logic [AW-1:0] cpu_addr_i,
  output logic          cpu_busy_o,
  output logic [AW:0]   ram_addr_o,
  input  logic [15:0]   ram_dout_i,
  output logic [AW:0]   buf_addr_o,
  output logic [15:0]   buf_din_o,
  output logic          buf_we_o,
  output logic          vid_bank_o,
  output logic          dma_busy_o
);

  localparam logic [AW-1:0] CntLast = '1;

  dma_st_e       st_q, st_d;
  logic          pending_q, pending_d;
  logic          src_half_q, src_half_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] cnt_l_q, cnt_l_d;
  logic          we_l_q, we_l_d;
  logic          bank_q, bank_d;
  logic          copying;
  logic          start_ok;

  assign copying  = (st_q == StCopy) || (st_q == StFlush);
  assign start_ok = cen_i && (!WAIT_BLANK || !lvbl_i);

  always_comb begin
    st_d       = st_q;
    pending_d  = pending_q;
    src_half_d = src_half_q;
    cnt_d      = cnt_q;
    cnt_l_d    = cnt_l_q;
    we_l_d     = 1'b0;
    bank_d     = bank_q;
    case (st_q)
      StIdle: begin
        if (obj_copy_i || pending_q) begin
          pending_d = 1'b1;
          st_d      = StArm;
        end
      end
      StArm: begin
        if (start_ok) begin
          src_half_d = mixpsel_i;
          pending_d  = 1'b0;
          cnt_d      = '0;
          st_d       = StCopy;
        end
      end
      StCopy: begin
        if (obj_copy_i) pending_d = 1'b1;
        if (cen_i) begin
          // Read issued now; the write lands next clk when RAM data is valid.
          we_l_d  = 1'b1;
          cnt_l_d = cnt_q;
          if (cnt_q == CntLast) st_d = StFlush;
          else                  cnt_d = cnt_q + 1'b1;
        end
      end
      StFlush: begin
        if (obj_copy_i) pending_d = 1'b1;
        bank_d = ~bank_q;
        st_d   = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q       <= StIdle;
      pending_q  <= 1'b0;
      src_half_q <= 1'b0;
      cnt_q      <= '0;
      cnt_l_q    <= '0;
      we_l_q     <= 1'b0;
      bank_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      pending_q  <= pending_d;
      src_half_q <= src_half_d;
      cnt_q      <= cnt_d;
      cnt_l_q    <= cnt_l_d;
      we_l_q     <= we_l_d;
      bank_q     <= bank_d;
    end
  end

  // The CPU owns the RAM port except while the copy is running.
  assign ram_addr_o = copying ? {src_half_q, cnt_q} : {mixpsel_i, cpu_addr_i};
  assign cpu_busy_o = cpu_cs_i && copying;
  assign buf_addr_o = {~bank_q, cnt_l_q};
  assign buf_din_o  = ram_dout_i;
  assign buf_we_o   = we_l_q;
  assign vid_bank_o = bank_q;
  assign dma_busy_o = pending_q || (st_q != StIdle);

endmodule
